// File: rtl/udp_rx_parser.sv
// udp_rx_parser
//
// Parses the 8-byte UDP header from the IPv4 payload byte stream. It filters
// on the destination port and publishes per-datagram metadata over a
// valid/ready handshake. It then forwards exactly the UDP payload bytes as a
// zero-latency pass-through, with a correct tlast.
//
// Parameters:
//   DATA_WIDTH  stream width in bits; only 8 (one byte per beat) is supported
//   LOCAL_PORT  accepted UDP destination port; 16'h0000 accepts every port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_*            IPv4 payload input stream (tdata/tvalid/tready/tlast)
//   m_axis_*            UDP payload output stream (tdata/tvalid/tready/tlast)
//   meta_valid/ready    datagram metadata handshake
//   meta_src_port       UDP source port
//   meta_dst_port       UDP destination port
//   meta_payload_len    UDP length minus 8
//   meta_checksum       raw UDP checksum field
//   err_truncated       one-cycle pulse: input tlast before payload complete
//   err_malformed       one-cycle pulse: runt header or UDP length < 8
//
// Optional build macro:
//   UDP_STATS_EN  adds saturating counters stat_rx_ok[15:0], stat_rx_drop[15:0]

module udp_rx_parser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [15:0] LOCAL_PORT = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic [15:0]           meta_src_port,
    output logic [15:0]           meta_dst_port,
    output logic [15:0]           meta_payload_len,
    output logic [15:0]           meta_checksum,
    output logic                  err_truncated,
    output logic                  err_malformed
`ifdef UDP_STATS_EN
    ,
    output logic [15:0]           stat_rx_ok,
    output logic [15:0]           stat_rx_drop
`endif
);

    typedef enum logic [2:0] {
        S_HDR,
        S_META,
        S_PAYLOAD,
        S_DRAIN,
        S_DROP
    } state_t;

    state_t      state;
    logic [2:0]  hdr_idx;
    logic [55:0] hdr_sr;      // header bytes 0..6, byte 0 in the top octet
    logic        hdr_tlast;   // header byte 7 also ended the IPv4 payload
    logic [15:0] remaining;

    logic [7:0]  in_byte;
    logic        s_fire;
    logic [15:0] hdr_dst_w;
    logic [15:0] hdr_len_w;
    logic        port_ok;

`ifdef UDP_STATS_EN
    logic        ok_evt;
    logic        reject_evt;
`endif

    assign in_byte   = s_axis_tdata[7:0];
    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign hdr_dst_w = hdr_sr[39:24];
    assign hdr_len_w = hdr_sr[23:8];
    assign port_ok   = (LOCAL_PORT == 16'h0000) || (hdr_dst_w == LOCAL_PORT);

    // Ready and the payload pass-through depend only on state, so the
    // payload path adds no latency.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (state)
            S_META: begin
                s_axis_tready = 1'b0;
            end
            S_PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = (remaining == 16'd1) || s_axis_tlast;
            end
            default: begin
                s_axis_tready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_HDR;
            hdr_idx          <= '0;
            hdr_sr           <= '0;
            hdr_tlast        <= 1'b0;
            remaining        <= '0;
            meta_valid       <= 1'b0;
            meta_src_port    <= '0;
            meta_dst_port    <= '0;
            meta_payload_len <= '0;
            meta_checksum    <= '0;
            err_truncated    <= 1'b0;
            err_malformed    <= 1'b0;
`ifdef UDP_STATS_EN
            ok_evt           <= 1'b0;
            reject_evt       <= 1'b0;
`endif
        end else begin
            err_truncated <= 1'b0;
            err_malformed <= 1'b0;
`ifdef UDP_STATS_EN
            ok_evt        <= 1'b0;
            reject_evt    <= 1'b0;
`endif
            unique case (state)
                S_HDR: begin
                    if (s_fire) begin
                        hdr_sr <= {hdr_sr[47:0], in_byte};
                        if (hdr_idx == 3'd7) begin
                            hdr_idx <= '0;
                            if (hdr_len_w < 16'd8) begin
                                err_malformed <= 1'b1;
                                state         <= s_axis_tlast ? S_HDR : S_DROP;
                            end else if (!port_ok) begin
`ifdef UDP_STATS_EN
                                reject_evt    <= 1'b1;
`endif
                                state         <= s_axis_tlast ? S_HDR : S_DROP;
                            end else begin
                                meta_valid       <= 1'b1;
                                meta_src_port    <= hdr_sr[55:40];
                                meta_dst_port    <= hdr_dst_w;
                                meta_payload_len <= hdr_len_w - 16'd8;
                                meta_checksum    <= {hdr_sr[7:0], in_byte};
                                hdr_tlast        <= s_axis_tlast;
                                state            <= S_META;
                            end
                        end else if (s_axis_tlast) begin
                            // Runt header: restart on the next byte.
                            err_malformed <= 1'b1;
                            hdr_idx       <= '0;
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                        end
                    end
                end

                S_META: begin
                    if (meta_ready) begin
                        meta_valid <= 1'b0;
                        if (meta_payload_len == 16'd0) begin
`ifdef UDP_STATS_EN
                            ok_evt <= 1'b1;
`endif
                            state  <= hdr_tlast ? S_HDR : S_DRAIN;
                        end else if (hdr_tlast) begin
                            // Metadata still goes out, but no payload follows.
                            err_truncated <= 1'b1;
                            state         <= S_HDR;
                        end else begin
                            remaining <= meta_payload_len;
                            state     <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (s_fire) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
`ifdef UDP_STATS_EN
                            ok_evt <= 1'b1;
`endif
                            state  <= s_axis_tlast ? S_HDR : S_DRAIN;
                        end else if (s_axis_tlast) begin
                            err_truncated <= 1'b1;
                            state         <= S_HDR;
                        end
                    end
                end

                S_DRAIN, S_DROP: begin
                    if (s_fire && s_axis_tlast) begin
                        state <= S_HDR;
                    end
                end

                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

`ifdef UDP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rx_ok   <= '0;
            stat_rx_drop <= '0;
        end else begin
            if (ok_evt && (stat_rx_ok != '1)) begin
                stat_rx_ok <= stat_rx_ok + 16'd1;
            end
            if ((reject_evt || err_truncated || err_malformed) && (stat_rx_drop != '1)) begin
                stat_rx_drop <= stat_rx_drop + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser
//
// Testbench for udp_rx_parser with LOCAL_PORT = 16'h0035. The stimulus is a
// mix of directed and $urandom frames. Expected results come from a
// frame-level reference model. The model works per whole frame (byte count,
// header fields) and keeps running totals plus order-sensitive hashes of the
// payload beats and metadata.

module tb_udp_rx_parser;

    localparam logic [15:0] LP = 16'h0035;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        meta_valid;
    logic        meta_ready;
    logic [15:0] meta_src_port;
    logic [15:0] meta_dst_port;
    logic [15:0] meta_payload_len;
    logic [15:0] meta_checksum;
    logic        err_truncated;
    logic        err_malformed;
`ifdef UDP_STATS_EN
    logic [15:0] stat_rx_ok;
    logic [15:0] stat_rx_drop;
`endif

    udp_rx_parser #(.DATA_WIDTH(8), .LOCAL_PORT(LP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .meta_valid(meta_valid), .meta_ready(meta_ready),
        .meta_src_port(meta_src_port), .meta_dst_port(meta_dst_port),
        .meta_payload_len(meta_payload_len), .meta_checksum(meta_checksum),
        .err_truncated(err_truncated), .err_malformed(err_malformed)
`ifdef UDP_STATS_EN
        , .stat_rx_ok(stat_rx_ok), .stat_rx_drop(stat_rx_drop)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model totals (written only by the stimulus thread)
    int unsigned exp_beats = 0, exp_meta_n = 0, exp_trunc = 0, exp_malf = 0;
    int unsigned exp_ok = 0, exp_drop = 0;
    logic [31:0] exp_hash = '0, exp_meta_hash = '0;

    // Observed totals (written only by the monitor)
    int unsigned got_beats = 0, got_meta_n = 0, got_trunc = 0, got_malf = 0;
    int unsigned bad_stall = 0, bad_stable = 0, wait_cycles = 0;
    logic [31:0] got_hash = '0, got_meta_hash = '0;
    logic [63:0] last_meta = '0;
    logic [8:0]  last_beat = '0;

    int m_mode = 0;   // m_axis_tready: 0 always, 1 random, 2 toggle
    int mr_mode = 0;  // meta_ready: 0 always, 1 random, 2 hold low 10 cycles
    bit mon_off = 1'b0;

    function automatic logic [31:0] mix(input logic [31:0] h, input logic [63:0] v);
        logic [31:0] r;
        r = (h ^ v[31:0]) * 32'h0100_0193;
        r = (r ^ v[63:32]) * 32'h0100_0193;
        return r;
    endfunction

    // Frame-level expectation: what must come out for one complete frame.
    function automatic void model(input byte_q_t fr);
        int unsigned n, ulen, plen, avail, nout;
        logic [15:0] src, dst, csum;
        n = fr.size();
        if (n < 8) begin exp_malf++; exp_drop++; return; end
        src  = {fr[0], fr[1]};
        dst  = {fr[2], fr[3]};
        ulen = {16'd0, fr[4], fr[5]};
        csum = {fr[6], fr[7]};
        if (ulen < 8) begin exp_malf++; exp_drop++; return; end
        if (LP != 16'h0000 && dst != LP) begin exp_drop++; return; end
        plen = ulen - 8;
        exp_meta_n++;
        exp_meta_hash = mix(exp_meta_hash, {src, dst, plen[15:0], csum});
        avail = n - 8;
        nout  = (avail < plen) ? avail : plen;
        for (int unsigned i = 0; i < nout; i++) begin
            exp_beats++;
            exp_hash = mix(exp_hash, {55'd0, (i == nout - 1), fr[8 + i]});
        end
        if (avail < plen) begin exp_trunc++; exp_drop++; end
        else exp_ok++;
    endfunction

    function automatic byte_q_t mk_frame(input logic [15:0] src, input logic [15:0] dst,
                                         input logic [15:0] ulen, input logic [15:0] csum,
                                         input int n_pay, input int n_pad);
        byte_q_t q;
        q.push_back(src[15:8]);  q.push_back(src[7:0]);
        q.push_back(dst[15:8]);  q.push_back(dst[7:0]);
        q.push_back(ulen[15:8]); q.push_back(ulen[7:0]);
        q.push_back(csum[15:8]); q.push_back(csum[7:0]);
        for (int i = 0; i < n_pay + n_pad; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic byte_q_t rand_frame();
        int kind, plen, n_pay, n_pad;
        logic [15:0] dst, ulen;
        byte_q_t q;
        kind  = $urandom_range(0, 9);
        plen  = $urandom_range(0, 20);
        dst   = (kind < 7) ? LP : 16'($urandom);
        ulen  = 16'(plen + 8);
        n_pay = plen;
        n_pad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
        if (kind == 7) ulen = 16'($urandom_range(0, 7));
        if (kind == 8) begin n_pay = $urandom_range(0, plen); n_pad = 0; end
        q = mk_frame(16'($urandom), dst, ulen, 16'($urandom), n_pay, n_pad);
        if (kind == 6) begin
            n_pay = $urandom_range(1, 7);
            while (q.size() > n_pay) void'(q.pop_back());
        end
        return q;
    endfunction

    // Entered and left at posedge+1; each byte has a bounded acceptance wait.
    task automatic send_frame(input byte_q_t fr, input bit with_last, input bit gaps);
        bit acc;
        for (int i = 0; i < int'(fr.size()); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fr[i];
            s_axis_tlast  = with_last && (i == int'(fr.size()) - 1);
            acc = 1'b0;
            for (int c = 0; c < 1000 && !acc; c++) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                vectors++; miscompares++;
                $display("FAIL input_accept byte %0d: got not accepted, required accepted within 1000 cycles", i);
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    always begin
        @(posedge clk); #1;
        case (m_mode)
            1: m_axis_tready = 1'($urandom);
            2: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b1;
        endcase
    end

    int held = 0;
    always begin
        @(posedge clk); #1;
        if (mr_mode == 2) begin
            if (meta_valid && held < 10) begin meta_ready = 1'b0; held++; end
            else begin meta_ready = 1'b1; if (!meta_valid) held = 0; end
        end else if (mr_mode == 1) meta_ready = 1'($urandom);
        else meta_ready = 1'b1;
    end

    logic        prev_wait = 1'b0;
    logic [63:0] prev_meta = '0;
    always @(negedge clk) begin
        logic [63:0] cur;
        cur = {meta_src_port, meta_dst_port, meta_payload_len, meta_checksum};
        if (!rst_n || mon_off) begin
            prev_wait = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                got_beats++;
                got_hash  = mix(got_hash, {55'd0, m_axis_tlast, m_axis_tdata});
                last_beat = {m_axis_tlast, m_axis_tdata};
            end
            if (meta_valid && meta_ready) begin
                got_meta_n++;
                got_meta_hash = mix(got_meta_hash, cur);
                last_meta     = cur;
            end
            if (meta_valid && !meta_ready) wait_cycles++;
            if (meta_valid && s_axis_tready) bad_stall++;
            if (meta_valid && prev_wait && cur != prev_meta) bad_stable++;
            if (err_truncated) got_trunc++;
            if (err_malformed) got_malf++;
            prev_wait = meta_valid && !meta_ready;
            prev_meta = cur;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b1; meta_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (meta_valid !== 1'b0) begin miscompares++; $display("FAIL reset_meta_valid got=%b exp=0", meta_valid); end
        vectors++; if ({meta_src_port, meta_dst_port, meta_payload_len, meta_checksum} !== 64'd0) begin
            miscompares++; $display("FAIL reset_meta_fields got=%h exp=0", {meta_src_port, meta_dst_port, meta_payload_len, meta_checksum}); end
        vectors++; if ({err_truncated, err_malformed} !== 2'b00) begin miscompares++; $display("FAIL reset_err got=%b exp=00", {err_truncated, err_malformed}); end
        vectors++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin miscompares++; $display("FAIL reset_m_axis got=%b exp=00", {m_axis_tvalid, m_axis_tlast}); end
`ifdef UDP_STATS_EN
        vectors++; if ({stat_rx_ok, stat_rx_drop} !== 32'd0) begin miscompares++; $display("FAIL reset_stats got=%h exp=0", {stat_rx_ok, stat_rx_drop}); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL reset_s_tready got=%b exp=1", s_axis_tready); end
    endtask

    task automatic test_directed();
        byte_q_t fa, fb, fc;
        m_mode = 0; mr_mode = 0;
        fa = mk_frame(16'd1234, 16'd53, 16'h000C, 16'hABCD, 0, 0);
        fa.push_back(8'h11); fa.push_back(8'h22); fa.push_back(8'h33); fa.push_back(8'h44);
        model(fa); send_frame(fa, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        vectors++; if (last_meta !== {16'd1234, 16'd53, 16'd4, 16'hABCD}) begin
            miscompares++; $display("FAIL directed_meta got=%h exp=%h", last_meta, {16'd1234, 16'd53, 16'd4, 16'hABCD}); end
        vectors++; if (last_beat !== 9'h144) begin miscompares++; $display("FAIL directed_last_beat got=%h exp=144", last_beat); end
        fb = fa;
        repeat (6) fb.push_back(8'($urandom));
        model(fb); send_frame(fb, 1'b1, 1'b0);
        fc = mk_frame(16'($urandom), LP, 16'd10, 16'($urandom), 2, 0);
        model(fc); send_frame(fc, 1'b1, 1'b1);
        repeat (30) @(posedge clk); #1;
        vectors++; if (got_beats !== exp_beats) begin miscompares++; $display("FAIL directed_beats got=%0d exp=%0d", got_beats, exp_beats); end
        vectors++; if (got_hash !== exp_hash) begin miscompares++; $display("FAIL directed_data got=%h exp=%h", got_hash, exp_hash); end
        vectors++; if (got_meta_n !== exp_meta_n || got_meta_hash !== exp_meta_hash) begin
            miscompares++; $display("FAIL directed_meta_seq got=%0d/%h exp=%0d/%h", got_meta_n, got_meta_hash, exp_meta_n, exp_meta_hash); end
        vectors++; if (got_trunc !== 0 || got_malf !== 0) begin miscompares++; $display("FAIL directed_errs got=%0d/%0d exp=0/0", got_trunc, got_malf); end
    endtask

    task automatic test_filter_errors();
        byte_q_t f;
        int unsigned t0, m0, b0;
        t0 = got_trunc; m0 = got_malf; b0 = got_beats;
        f = mk_frame(16'd7, 16'h0050, 16'd12, 16'd0, 4, 0);
        model(f); send_frame(f, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        vectors++; if (got_beats !== b0) begin miscompares++; $display("FAIL filter_no_beats got=%0d exp=%0d", got_beats, b0); end
        f = mk_frame(16'd9, LP, 16'h0010, 16'd1, 3, 0);
        model(f); send_frame(f, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        vectors++; if (got_trunc - t0 !== 1) begin miscompares++; $display("FAIL trunc_once got=%0d exp=1", got_trunc - t0); end
        vectors++; if (got_beats - b0 !== 3 || last_beat[8] !== 1'b1) begin
            miscompares++; $display("FAIL trunc_fwd got=%0d last=%b exp=3 last=1", got_beats - b0, last_beat[8]); end
        f = mk_frame(16'd1, LP, 16'h0006, 16'd0, 3, 0);
        model(f); send_frame(f, 1'b1, 1'b0);
        f = mk_frame(16'd1, LP, 16'd8, 16'd0, 0, 0);
        while (f.size() > 5) void'(f.pop_back());
        model(f); send_frame(f, 1'b1, 1'b0);
        f = mk_frame(16'd77, LP, 16'd13, 16'h5A5A, 5, 0);
        model(f); send_frame(f, 1'b1, 1'b0);
        repeat (30) @(posedge clk); #1;
        vectors++; if (got_malf - m0 !== 2) begin miscompares++; $display("FAIL malformed_count got=%0d exp=2", got_malf - m0); end
        vectors++; if (last_meta !== {16'd77, LP, 16'd5, 16'h5A5A}) begin
            miscompares++; $display("FAIL after_runt_meta got=%h exp=%h", last_meta, {16'd77, LP, 16'd5, 16'h5A5A}); end
        vectors++; if (got_beats !== exp_beats || got_hash !== exp_hash) begin
            miscompares++; $display("FAIL errs_data got=%0d/%h exp=%0d/%h", got_beats, got_hash, exp_beats, exp_hash); end
        vectors++; if (got_meta_n !== exp_meta_n || got_meta_hash !== exp_meta_hash) begin
            miscompares++; $display("FAIL errs_meta got=%0d/%h exp=%0d/%h", got_meta_n, got_meta_hash, exp_meta_n, exp_meta_hash); end
`ifdef UDP_STATS_EN
        vectors++; if (stat_rx_ok !== 16'(exp_ok) || stat_rx_drop !== 16'(exp_drop)) begin
            miscompares++; $display("FAIL errs_stats got=%0d/%0d exp=%0d/%0d", stat_rx_ok, stat_rx_drop, exp_ok, exp_drop); end
`endif
    endtask

    task automatic test_backpressure();
        byte_q_t f;
        int unsigned w0;
        w0 = wait_cycles;
        m_mode = 2; mr_mode = 2;
        for (int k = 0; k < 4; k++) begin
            f = mk_frame(16'($urandom), LP, 16'($urandom_range(8, 24)), 16'($urandom), 0, 0);
            for (int i = 0; i < int'({f[4], f[5]}) - 8; i++) f.push_back(8'($urandom));
            model(f); send_frame(f, 1'b1, 1'b0);
        end
        repeat (30) @(posedge clk); #1;
        vectors++; if (wait_cycles - w0 < 40) begin miscompares++; $display("FAIL bp_meta_hold got=%0d exp>=40", wait_cycles - w0); end
        vectors++; if (bad_stall !== 0) begin miscompares++; $display("FAIL bp_s_tready_in_meta got=%0d exp=0", bad_stall); end
        vectors++; if (bad_stable !== 0) begin miscompares++; $display("FAIL bp_meta_stable got=%0d exp=0", bad_stable); end
        vectors++; if (got_beats !== exp_beats || got_hash !== exp_hash) begin
            miscompares++; $display("FAIL bp_data got=%0d/%h exp=%0d/%h", got_beats, got_hash, exp_beats, exp_hash); end
        vectors++; if (got_meta_n !== exp_meta_n || got_meta_hash !== exp_meta_hash) begin
            miscompares++; $display("FAIL bp_meta got=%0d/%h exp=%0d/%h", got_meta_n, got_meta_hash, exp_meta_n, exp_meta_hash); end
    endtask

    task automatic test_random();
        byte_q_t f;
        m_mode = 1; mr_mode = 1;
        for (int k = 0; k < 60; k++) begin
            f = rand_frame();
            model(f); send_frame(f, 1'b1, 1'b1);
        end
        repeat (30) @(posedge clk); #1;
        vectors++; if (got_beats !== exp_beats || got_hash !== exp_hash) begin
            miscompares++; $display("FAIL rand_data got=%0d/%h exp=%0d/%h", got_beats, got_hash, exp_beats, exp_hash); end
        vectors++; if (got_meta_n !== exp_meta_n || got_meta_hash !== exp_meta_hash) begin
            miscompares++; $display("FAIL rand_meta got=%0d/%h exp=%0d/%h", got_meta_n, got_meta_hash, exp_meta_n, exp_meta_hash); end
        vectors++; if (got_trunc !== exp_trunc || got_malf !== exp_malf) begin
            miscompares++; $display("FAIL rand_errs got=%0d/%0d exp=%0d/%0d", got_trunc, got_malf, exp_trunc, exp_malf); end
        vectors++; if (bad_stall !== 0 || bad_stable !== 0) begin
            miscompares++; $display("FAIL rand_meta_hold got=%0d/%0d exp=0/0", bad_stall, bad_stable); end
`ifdef UDP_STATS_EN
        vectors++; if (stat_rx_ok !== 16'(exp_ok) || stat_rx_drop !== 16'(exp_drop)) begin
            miscompares++; $display("FAIL rand_stats got=%0d/%0d exp=%0d/%0d", stat_rx_ok, stat_rx_drop, exp_ok, exp_drop); end
`endif
    endtask

    task automatic test_reset_mid_payload();
        byte_q_t f;
        m_mode = 0; mr_mode = 0; mon_off = 1'b1;
        f = mk_frame(16'h1111, LP, 16'd18, 16'h2222, 3, 0);
        send_frame(f, 1'b0, 1'b0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h99; s_axis_tlast = 1'b0;
        #1;
        vectors++; if ({m_axis_tvalid, m_axis_tdata} !== 9'h199) begin
            miscompares++; $display("FAIL mid_payload_passthru got=%h exp=199", {m_axis_tvalid, m_axis_tdata}); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({m_axis_tvalid, m_axis_tlast, meta_valid, err_truncated, err_malformed} !== 5'd0) begin
            miscompares++; $display("FAIL rst_mid_outputs got=%b exp=00000", {m_axis_tvalid, m_axis_tlast, meta_valid, err_truncated, err_malformed}); end
        vectors++; if ({meta_src_port, meta_dst_port, meta_payload_len, meta_checksum} !== 64'd0) begin
            miscompares++; $display("FAIL rst_mid_meta got=%h exp=0", {meta_src_port, meta_dst_port, meta_payload_len, meta_checksum}); end
        vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_s_tready got=%b exp=1", s_axis_tready); end
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ok = 0; exp_drop = 0; mon_off = 1'b0;
        f = mk_frame(16'h0BAD, LP, 16'd12, 16'hF00D, 4, 0);
        model(f); send_frame(f, 1'b1, 1'b0);
        repeat (30) @(posedge clk); #1;
        vectors++; if (last_meta !== {16'h0BAD, LP, 16'd4, 16'hF00D}) begin
            miscompares++; $display("FAIL post_rst_meta got=%h exp=%h", last_meta, {16'h0BAD, LP, 16'd4, 16'hF00D}); end
        vectors++; if (got_beats !== exp_beats || got_hash !== exp_hash) begin
            miscompares++; $display("FAIL post_rst_data got=%0d/%h exp=%0d/%h", got_beats, got_hash, exp_beats, exp_hash); end
`ifdef UDP_STATS_EN
        vectors++; if (stat_rx_ok !== 16'(exp_ok) || stat_rx_drop !== 16'(exp_drop)) begin
            miscompares++; $display("FAIL post_rst_stats got=%0d/%0d exp=%0d/%0d", stat_rx_ok, stat_rx_drop, exp_ok, exp_drop); end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_filter_errors();
        test_backpressure();
        test_random();
        test_reset_mid_payload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
Consumes the IPv4 payload byte stream produced by the Ethernet/IPv4 receive stage. Parses the 8-byte UDP header and filters on destination port. Publishes per-datagram metadata over a valid/ready handshake, then forwards exactly the UDP payload bytes with a correct tlast. Sits between the IPv4 header handler and the application-side byte consumer.

Parameters:
DATA_WIDTH, 8, stream width in bits; only 8 (one byte per beat) is supported
LOCAL_PORT, 16'h0000, accepted UDP destination port; 0 accepts every port

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_axis_tdata  input  DATA_WIDTH  IPv4 payload byte
s_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  input beat accepted
s_axis_tlast  input  1  last byte of IPv4 payload
m_axis_tdata  output  DATA_WIDTH  UDP payload byte
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last UDP payload byte
meta_valid  output  1  datagram metadata valid
meta_ready  input  1  metadata accepted
meta_src_port  output  16  UDP source port
meta_dst_port  output  16  UDP destination port
meta_payload_len  output  16  UDP length minus 8
meta_checksum  output  16  raw UDP checksum field
err_truncated  output  1  one-cycle pulse: s_axis_tlast arrived before payload complete
err_malformed  output  1  one-cycle pulse: runt header or UDP length < 8

Behaviour:
- A beat transfers when s_axis_tvalid && s_axis_tready. Header fields are big-endian: bytes 0-1 src port, 2-3 dst port, 4-5 length, 6-7 checksum.
- States and s_axis_tready:
  - S_HDR: tready=1.
  - S_META: tready=0.
  - S_PAYLOAD: tready=m_axis_tready.
  - S_DRAIN: tready=1.
  - S_DROP: tready=1.
- S_HDR: a 3-bit byte index captures the fields. On byte 7:
  - length<8 → err_malformed pulse, go to S_DROP (or S_HDR if that byte has tlast).
  - LOCAL_PORT!=0 and dst port != LOCAL_PORT → S_DROP (or S_HDR if tlast).
  - Otherwise register metadata, set meta_valid=1 the next cycle, go to S_META.
  - tlast on byte index <7 → err_malformed pulse, return to S_HDR, index cleared, no meta.
- S_META: meta_valid held with stable fields until meta_ready is sampled high. On that cycle:
  - payload_len=0 → S_DRAIN if the header byte did not carry tlast, else S_HDR.
  - Otherwise → S_PAYLOAD, remaining counter = payload_len.
- Header byte 7 carrying tlast with payload_len>0: still publish meta, then pulse err_truncated on meta handshake and return to S_HDR.
- S_PAYLOAD: combinational pass-through, no latency.
  - m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid.
  - m_axis_tlast=1 when remaining==1 or s_axis_tlast.
  - On each transfer, remaining decrements.
  - remaining reaches 0 with no s_axis_tlast → S_DRAIN; discard trailing bytes (Ethernet padding).
  - remaining==1 together with s_axis_tlast → S_HDR, clean completion.
  - s_axis_tlast with remaining>1 → err_truncated pulse, tlast forwarded, S_HDR.
- S_DRAIN / S_DROP: consume bytes until s_axis_tlast, then S_HDR. m_axis_tvalid=0 in all states except S_PAYLOAD.
- Counters are 16-bit; no wrap is possible since remaining ≤ 65527.
- Reset: state S_HDR, index 0, meta_valid 0, all meta fields 0, err pulses 0, m_axis_tvalid 0, m_axis_tlast 0, stats 0.
- Reset is asynchronous and discards any in-flight datagram. After release, the first byte is treated as header byte 0.

Optional Feature:
UDP_STATS_EN:
- Defined: adds outputs stat_rx_ok[15:0] and stat_rx_drop[15:0], both saturating at 16'hFFFF and cleared only by reset.
  - ok increments when a datagram completes its payload (or has a zero-length payload) without truncation.
  - drop increments on port-filter reject, err_malformed, or err_truncated.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- LOCAL_PORT=0. Header 04 D2 00 35 00 0C AB CD, payload 11 22 33 44 with tlast on 44 → meta src=1234, dst=53, len=4, csum=ABCD. m_axis delivers 11 22 33 44 with tlast on 44. No errors.
- Same datagram plus 6 padding bytes, tlast on the final pad → exactly 4 bytes forwarded with tlast on 44. Padding consumed. Next datagram parses correctly.
- LOCAL_PORT=16'h0035, dst port 0x0050 → no meta_valid, no m_axis beats, stream consumed to tlast, stat_rx_drop=1 (with UDP_STATS_EN).
- Length field 0x0010, only 3 payload bytes, tlast on the 3rd → 3 bytes forwarded, tlast on the 3rd, err_truncated pulses exactly once.
- Length 0x0006 → err_malformed pulse, no meta. tlast after 5 header bytes → err_malformed pulse, index reset, next frame parses.
- Hold meta_ready=0 for 10 cycles, toggle m_axis_tready every cycle:
  - s_axis_tready is 0 and meta stable throughout S_META.
  - No payload byte is lost or duplicated.
  - Asserting rst_n low mid-payload returns all outputs to their reset values immediately.
